counter_74161_lockstep: RTL and testbench

Dual-redundant 74161-style 4-bit synchronous binary counter with a built-in lockstep comparator. Two identical counter channels receive the same load, enable and clear inputs. The primary channel drives the outputs. A bitwise XOR of the two channel values, OR-reduced, flags any divergence. The block is the data source for the shift-register stage and acts as its self-checking front end.

---
 rtl/counter_74161_lockstep_pkg.sv | 33 +++
 rtl/counter_74161_lockstep_cell.sv | 51 +++++
 rtl/counter_74161_lockstep.sv | 80 ++++++++
 tb/tb_counter_74161_lockstep.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/counter_74161_lockstep_pkg.sv
// ============================================================================
// Module  : counter_74161_lockstep_pkg
// Brief   : Shared width, terminal-count constant and cell operation encoding
// Rev     : 1.0
// ============================================================================
`default_nettype none

package counter_74161_lockstep_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned CNT_MAX   = (2 ** DEF_WIDTH) - 1;

  // Per-edge action of one counter channel; clear is asynchronous and sits outside this.
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_COUNT = 2'd2
  } cell_op_e;

  function automatic cell_op_e decode_op(input logic load_n, input logic ent, input logic enp);
    cell_op_e op;
    op = OP_HOLD;
    if (!load_n) begin
      op = OP_LOAD;
    end else if (ent && enp) begin
      op = OP_COUNT;
    end
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter_74161_lockstep_cell.sv
// ============================================================================
// Module  : counter_cell_74161
// Brief   : One 74161-style up counter channel with async clear and ripple carry
// Rev     : 1.0
// ============================================================================
`default_nettype none

module counter_cell_74161
  import counter_74161_lockstep_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             CLRBAR,
  input  logic [WIDTH-1:0] DIC,
  input  logic             LOAD,
  input  logic             ENT,
  input  logic             ENP,
  output logic [WIDTH-1:0] Q,
  output logic             RCO
);

  cell_op_e         op;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    op    = decode_op(LOAD, ENT, ENP);
    cnt_d = cnt_q;
    case (op)
      OP_LOAD:  cnt_d = DIC;
      OP_COUNT: cnt_d = cnt_q + WIDTH'(1);
      default:  cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK or negedge CLRBAR) begin
    if (!CLRBAR) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Q   = cnt_q;
  // Carry depends on ENT only, so a cascade stalls via ENT while ENP pauses locally.
  assign RCO = ENT & (cnt_q == {WIDTH{1'b1}});

endmodule

`default_nettype wire

// File: rtl/counter_74161_lockstep.sv
// ============================================================================
// Module  : counter_74161_lockstep
// Brief   : Dual-channel 74161 counter with lockstep comparator and sticky error
// Rev     : 1.0
// ============================================================================
`default_nettype none

module counter_74161_lockstep
  import counter_74161_lockstep_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             CLRBAR,
  input  logic [WIDTH-1:0] DIC,
  input  logic             LOAD,
  input  logic             ENT,
  input  logic             ENP,
  input  logic             INJ,
  output logic [WIDTH-1:0] QC,
  output logic             RCO,
  output logic             MISMATCH,
  output logic             ERR
);

  logic [WIDTH-1:0] q_a;
  logic [WIDTH-1:0] q_b;
  logic [WIDTH-1:0] inj_mask;
  logic [WIDTH-1:0] diff;
  logic             rco_a;
  logic             rco_b_unused;
  logic             err_q;
  logic             err_d;

  counter_cell_74161 #(.WIDTH(WIDTH)) u_chan_a (
    .CLK    (CLK),
    .CLRBAR (CLRBAR),
    .DIC    (DIC),
    .LOAD   (LOAD),
    .ENT    (ENT),
    .ENP    (ENP),
    .Q      (q_a),
    .RCO    (rco_a)
  );

  counter_cell_74161 #(.WIDTH(WIDTH)) u_chan_b (
    .CLK    (CLK),
    .CLRBAR (CLRBAR),
    .DIC    (DIC),
    .LOAD   (LOAD),
    .ENT    (ENT),
    .ENP    (ENP),
    .Q      (q_b),
    .RCO    (rco_b_unused)
  );

  // Injection flips channel B bit 0 only on the comparator path, never in its state.
  always_comb begin
    inj_mask    = '0;
    inj_mask[0] = INJ;
    diff        = q_a ^ (q_b ^ inj_mask);
    err_d       = err_q | (|diff);
  end

  always_ff @(posedge CLK or negedge CLRBAR) begin
    if (!CLRBAR) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign QC       = q_a;
  assign RCO      = rco_a;
  assign MISMATCH = |diff;
  assign ERR      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_counter_74161_lockstep.sv
// ============================================================================
// Module  : tb_counter_74161_lockstep
// Brief   : Directed self-checking bench for the lockstep 74161 counter
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_counter_74161_lockstep;

  logic       CLK;
  logic       CLRBAR;
  logic [3:0] DIC;
  logic       LOAD;
  logic       ENT;
  logic       ENP;
  logic       INJ;
  logic [3:0] QC;
  logic       RCO;
  logic       MISMATCH;
  logic       ERR;

  int checks;
  int failures;

  counter_74161_lockstep #(.WIDTH(4)) dut (
    .CLK      (CLK),
    .CLRBAR   (CLRBAR),
    .DIC      (DIC),
    .LOAD     (LOAD),
    .ENT      (ENT),
    .ENP      (ENP),
    .INJ      (INJ),
    .QC       (QC),
    .RCO      (RCO),
    .MISMATCH (MISMATCH),
    .ERR      (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    CLRBAR = 1'b0; LOAD = 1'b1; ENT = 1'b1; ENP = 1'b1; INJ = 1'b0; DIC = 4'd0;
    #20;
    checks++; if (QC !== 4'd0)  begin failures++; $display("FAIL reset_qc got=%0d exp=0", QC); end
    checks++; if (RCO !== 1'b0) begin failures++; $display("FAIL reset_rco got=%b exp=0", RCO); end
    checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", ERR); end
    checks++; if (MISMATCH !== 1'b0) begin failures++; $display("FAIL reset_mm_inj0 got=%b exp=0", MISMATCH); end
    INJ = 1'b1;
    #1;
    checks++; if (MISMATCH !== 1'b1) begin failures++; $display("FAIL reset_mm_inj1 got=%b exp=1", MISMATCH); end
    tick();
    checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL reset_err_held got=%b exp=0", ERR); end
    checks++; if (QC !== 4'd0)  begin failures++; $display("FAIL reset_no_count got=%0d exp=0", QC); end
    INJ = 1'b0;
    CLRBAR = 1'b1;
  endtask

  task automatic test_count_wrap();
    for (int i = 1; i <= 15; i++) begin
      tick();
      checks++;
      if (QC !== 4'(i)) begin failures++; $display("FAIL count_step got=%0d exp=%0d", QC, i); end
    end
    checks++; if (RCO !== 1'b1) begin failures++; $display("FAIL count_rco15 got=%b exp=1", RCO); end
    tick();
    checks++; if (QC !== 4'd0)  begin failures++; $display("FAIL count_wrap got=%0d exp=0", QC); end
    checks++; if (RCO !== 1'b0) begin failures++; $display("FAIL count_rco0 got=%b exp=0", RCO); end
  endtask

  task automatic test_load();
    DIC = 4'd9; LOAD = 1'b0; ENT = 1'b1; ENP = 1'b1;
    tick();
    checks++; if (QC !== 4'd9) begin failures++; $display("FAIL load_wins got=%0d exp=9", QC); end
    LOAD = 1'b1;
    tick();
    checks++; if (QC !== 4'd10) begin failures++; $display("FAIL load_cnt1 got=%0d exp=10", QC); end
    tick();
    checks++; if (QC !== 4'd11) begin failures++; $display("FAIL load_cnt2 got=%0d exp=11", QC); end
    ENT = 1'b0; ENP = 1'b0; DIC = 4'd3; LOAD = 1'b0;
    tick();
    checks++; if (QC !== 4'd3) begin failures++; $display("FAIL load_no_en got=%0d exp=3", QC); end
    LOAD = 1'b1; ENT = 1'b1; ENP = 1'b1;
  endtask

  task automatic test_enables();
    DIC = 4'd15; LOAD = 1'b0;
    tick();
    LOAD = 1'b1; ENP = 1'b0; ENT = 1'b1;
    tick();
    checks++; if (QC !== 4'd15) begin failures++; $display("FAIL enp0_hold got=%0d exp=15", QC); end
    checks++; if (RCO !== 1'b1) begin failures++; $display("FAIL enp0_rco got=%b exp=1", RCO); end
    ENT = 1'b0; ENP = 1'b1;
    #1;
    checks++; if (RCO !== 1'b0) begin failures++; $display("FAIL ent0_rco_comb got=%b exp=0", RCO); end
    tick();
    checks++; if (QC !== 4'd15) begin failures++; $display("FAIL ent0_hold got=%0d exp=15", QC); end
    checks++; if (RCO !== 1'b0) begin failures++; $display("FAIL ent0_rco got=%b exp=0", RCO); end
    DIC = 4'd14; LOAD = 1'b0; ENT = 1'b1;
    tick();
    LOAD = 1'b1;
    checks++; if (RCO !== 1'b0) begin failures++; $display("FAIL rco_at14 got=%b exp=0", RCO); end
    tick();
    checks++; if (RCO !== 1'b1) begin failures++; $display("FAIL rco_at15 got=%b exp=1", RCO); end
  endtask

  task automatic test_async_clear();
    DIC = 4'd7; LOAD = 1'b0; ENT = 1'b1; ENP = 1'b1;
    tick();
    LOAD = 1'b1;
    checks++; if (QC !== 4'd7) begin failures++; $display("FAIL aclr_pre got=%0d exp=7", QC); end
    #2;
    CLRBAR = 1'b0;
    #1;
    checks++; if (QC !== 4'd0) begin failures++; $display("FAIL aclr_immediate got=%0d exp=0", QC); end
    tick();
    checks++; if (QC !== 4'd0) begin failures++; $display("FAIL aclr_held got=%0d exp=0", QC); end
    #2;
    CLRBAR = 1'b1;
    tick();
    checks++; if (QC !== 4'd1) begin failures++; $display("FAIL aclr_release got=%0d exp=1", QC); end
  endtask

  task automatic test_lockstep();
    logic [3:0] exp_q;
    exp_q = QC;
    for (int i = 0; i < 32; i++) begin
      tick();
      exp_q = exp_q + 4'd1;
      checks++;
      if (QC !== exp_q || MISMATCH !== 1'b0 || ERR !== 1'b0) begin
        failures++;
        $display("FAIL lockstep_run cyc=%0d q=%0d exp=%0d mm=%b err=%b exp_flags=00", i, QC, exp_q, MISMATCH, ERR);
      end
    end
    INJ = 1'b1;
    #1;
    checks++; if (MISMATCH !== 1'b1) begin failures++; $display("FAIL inj_mm got=%b exp=1", MISMATCH); end
    checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL inj_err_early got=%b exp=0", ERR); end
    tick();
    INJ = 1'b0;
    #1;
    checks++; if (ERR !== 1'b1) begin failures++; $display("FAIL inj_err_set got=%b exp=1", ERR); end
    checks++; if (MISMATCH !== 1'b0) begin failures++; $display("FAIL inj_mm_clr got=%b exp=0", MISMATCH); end
    DIC = 4'd5; LOAD = 1'b0;
    tick();
    LOAD = 1'b1;
    tick();
    checks++; if (ERR !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", ERR); end
    checks++; if (QC !== 4'd6) begin failures++; $display("FAIL err_cnt got=%0d exp=6", QC); end
    #2;
    CLRBAR = 1'b0;
    #1;
    checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", ERR); end
    tick();
    CLRBAR = 1'b1;
    tick();
    checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL err_after_clr got=%b exp=0", ERR); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] vals [4];
    vals[0] = 4'd12; vals[1] = 4'd0; vals[2] = 4'd15; vals[3] = 4'd6;
    LOAD = 1'b0; ENT = 1'b1; ENP = 1'b1;
    for (int i = 0; i < 4; i++) begin
      DIC = vals[i];
      tick();
      checks++;
      if (QC !== vals[i]) begin failures++; $display("FAIL b2b_load idx=%0d got=%0d exp=%0d", i, QC, vals[i]); end
    end
    LOAD = 1'b1;
    tick();
    checks++; if (QC !== 4'd7) begin failures++; $display("FAIL b2b_count got=%0d exp=7", QC); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_count_wrap();
    test_load();
    test_enables();
    test_async_clear();
    test_lockstep();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
